// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access unit: size encodings,
// FSM state encoding and the default word-index width.
package dmem_pkg;

    localparam int RAMSIZE_DEF = 12;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: extracts/extends load data from a memory word
// and merges right-justified store data into the addressed lane(s).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        if (size == SZ_BYTE)
            load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
        else if (size == SZ_HALF)
            load_data = {{16{is_signed & half_sel[15]}}, half_sel};
    end

    // Each lane either keeps the old memory byte or takes the matching store byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = gi[1:0];
            logic       lane_hit;
            logic [7:0] lane_src;

            always_comb begin
                lane_hit = 1'b1;
                lane_src = wdata[gi*8 +: 8];
                if (size == SZ_BYTE) begin
                    lane_hit = (offset == LANE);
                    lane_src = wdata[7:0];
                end else if (size == SZ_HALF) begin
                    lane_hit = (offset[1] == LANE[1]);
                    lane_src = LANE[0] ? wdata[15:8] : wdata[7:0];
                end
            end

            assign merged[gi*8 +: 8] = lane_hit ? lane_src : rdata[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store engine driving a word-only data memory with sub-word RMW.
// Optional macro DMEM_ACCESS_MISALIGN_TRAP_EN: trap misaligned half/word accesses.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int RAMSIZE = RAMSIZE_DEF,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic [1:0]  offset_reg;
    logic        signed_reg;
    logic [31:0] wdata_reg;

    logic [1:0]  size_norm;
    logic [1:0]  offset_norm;
    logic        misaligned;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:RAMSIZE+2];
    assign req_ready = (state_reg == IDLE);

    // Reserved size 11 behaves as a word; offsets are masked to the access size.
    always_comb begin
        size_norm   = (req_size == 2'b11) ? SZ_WORD : req_size;
        offset_norm = 2'b00;
        if (size_norm == SZ_BYTE)
            offset_norm = req_addr[1:0];
        else if (size_norm == SZ_HALF)
            offset_norm = {req_addr[1], 1'b0};
`ifdef DMEM_ACCESS_MISALIGN_TRAP_EN
        misaligned = ((size_norm == SZ_HALF) && req_addr[0]) ||
                     ((size_norm == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned)
                        state_next = RESP;
                    else if (req_we && size_norm == SZ_WORD)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = we_reg ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    dmem_lane_align u_align (
        .size      (size_reg),
        .offset    (offset_reg),
        .is_signed (signed_reg),
        .rdata     (mem_rdata),
        .wdata     (wdata_reg),
        .load_data (load_data),
        .merged    (merged)
    );

`ifdef DMEM_ACCESS_MISALIGN_TRAP_EN
    logic resp_err_reg;
    assign resp_err = resp_err_reg;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            size_reg   <= SZ_WORD;
            offset_reg <= 2'b00;
            signed_reg <= 1'b0;
            wdata_reg  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wren   <= 1'b0;
`ifdef DMEM_ACCESS_MISALIGN_TRAP_EN
            resp_err_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg     <= req_we;
                        size_reg   <= size_norm;
                        offset_reg <= offset_norm;
                        signed_reg <= req_signed;
                        wdata_reg  <= req_wdata;
                        mem_addr   <= {{(32-RAMSIZE){1'b0}}, req_addr[RAMSIZE+1:2]};
                        if (state_next == WR) begin
                            mem_wdata <= req_wdata;
                            mem_wren  <= 1'b1;
                        end
                        if (state_next == RESP) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
`ifdef DMEM_ACCESS_MISALIGN_TRAP_EN
                            resp_err_reg <= 1'b1;
`endif
                        end
                    end
                end
                RD: begin
                    if (we_reg) begin
                        mem_wdata <= merged;
                        mem_wren  <= 1'b1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
`ifdef DMEM_ACCESS_MISALIGN_TRAP_EN
                        resp_err_reg <= 1'b0;
`endif
                    end
                end
                WR: begin
                    mem_wren   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
`ifdef DMEM_ACCESS_MISALIGN_TRAP_EN
                    resp_err_reg <= 1'b0;
`endif
                end
                default: begin
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator side of the data-memory interface: the load/store engine that drives the word-only, level-sensitive data memory on behalf of the pipeline's MEM stage.
- Accepts byte-addressed load/store requests of byte, halfword or word size.
- Converts each request to word-index accesses and performs read-modify-write for sub-word stores, because the memory has only a whole-word write enable.
- Returns sign/zero-extended load data through a valid/ready request and one-shot response handshake.

Parameters:
- RAMSIZE, 12, number of word-index bits the memory decodes; mem_addr[RAMSIZE-1:0] carries the word index, upper bits are driven 0.
- DATA_W, 32, data width; fixed at 32, exposed only for readability.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle pulse: operation complete.
- resp_rdata  output  32  extended load data; 0 for stores.
- resp_err  output  1  misaligned request (see Optional Feature).
- mem_addr  output  32  word index to memory.
- mem_wdata  output  32  word write data.
- mem_wren  output  1  memory write enable.
- mem_rdata  input  32  memory read data (combinational).

Behaviour:
- Reset (async, reset_n=0): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_addr=0; mem_wdata=0; mem_wren=0. Reset mid-operation abandons it; no partial write may be left asserted.
- All mem_* outputs are registered, so mem_wren never glitches. mem_wren is 1 only in state WR.
- Handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE. Request fields are latched at acceptance. No backpressure on the response.
- Word index: req_addr[RAMSIZE+1:2]. Byte offset: req_addr[1:0]. Lanes are little-endian; offset 0 maps to bits [7:0].
- FSM states: IDLE, RD, WR, RESP.
  - IDLE -> RD: load, or sub-word store.
  - IDLE -> WR: word store.
  - RD -> RESP: load; mem_rdata captured at the end of the RD cycle.
  - RD -> WR: sub-word store; mem_rdata captured, target lane(s) replaced by req_wdata[7:0] or [15:0], merged word placed on mem_wdata.
  - WR -> RESP.
  - RESP -> IDLE, with resp_valid=1 for exactly that cycle.
- Latency, from the acceptance edge to resp_valid: word load 2 cycles, word store 2 cycles, sub-word store 3 cycles. Back-to-back throughput: the next request is accepted in the cycle after RESP.
- Load extraction:
  - byte: lane addr[1:0].
  - halfword: lane addr[1].
  - Extension per req_signed. Word loads ignore req_signed.
- resp_rdata is held until the next response; it is 0 for stores.
- Size 11 behaves exactly like 10.

Optional Feature:
- Macro DMEM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, skips RD and WR: IDLE -> RESP.
  - resp_err=1 with the resp_valid pulse; resp_rdata=0; mem_wren stays 0.
- Undefined:
  - Offending low address bits are masked; halfword uses addr[1] only, word ignores addr[1:0].
  - The access proceeds normally; resp_err is tied 0.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state enum;
  - RAMSIZE default.
- One sub-module, dmem_lane_align, is purely combinational. It extracts and extends load data and merges store data into a word, given size, offset and signedness. The FSM, registers and handshake stay in the top.

Test Plan:
- Word store then load: store 0xDEADBEEF at addr 0x10. Required: mem_wren=1 for one cycle, with mem_addr=4 and mem_wdata=0xDEADBEEF. Then load the word at 0x10; resp_rdata=0xDEADBEEF, 2 cycles after acceptance.
- Byte RMW: memory word 4 = 0x11223344; sb 0xAA to addr 0x11. Required: the write is 0x1122AA44 and resp_valid comes 3 cycles after acceptance. Then lb at 0x11 returns 0xFFFFFFAA, and lbu returns 0x000000AA.
- Halfword: sh 0x8001 to addr 0x12 over 0x1122AA44. Required: the word becomes 0x8001AA44. lh returns 0xFFFF8001 and lhu returns 0x00008001.
- Misaligned: lw at 0x13.
  - With macro: resp_valid with resp_err=1 one cycle after acceptance, and no memory write.
  - Without macro: returns word 4 with resp_err=0.
- Reset mid-RMW: assert reset_n=0 during the RD state of an sb. Required: mem_wren=0 immediately, all outputs at reset values, and memory word 4 unchanged.
- Back-to-back: hold req_valid high with 3 queued loads. Required: req_ready is low from the cycle after each acceptance until the cycle after RESP, and exactly 3 resp_valid pulses occur, in order.
